// File: rtl/mlp_seq_if.sv
// mlp_seq_if: handshake bundle between the MLP sequencer and its host.
// Signals:
//    cmd_valid_i / cmd_ready_o / cmd_mode_i : command (0 = load weights, 1 = inference)
//    in_valid_i  / in_ready_o               : input beat (weights or activations)
//    out_valid_o / out_ready_i              : result beat
// The _i/_o suffixes are relative to the sequencer. The sequencer binds the
// slave modport and the host binds the master modport.
interface mlp_seq_if;
   logic cmd_valid_i;
   logic cmd_ready_o;
   logic cmd_mode_i;
   logic in_valid_i;
   logic in_ready_o;
   logic out_valid_o;
   logic out_ready_i;

   modport slave (
      input  cmd_valid_i, cmd_mode_i, in_valid_i, out_ready_i,
      output cmd_ready_o, in_ready_o, out_valid_o
   );

   modport master (
      output cmd_valid_i, cmd_mode_i, in_valid_i, out_ready_i,
      input  cmd_ready_o, in_ready_o, out_valid_o
   );
endinterface

// File: rtl/mlp_seq.sv
// mlp_seq: control sequencer for a layer-by-layer MLP engine. It supports
// three operations:
//    - Weight load: stream weights into the weight memory.
//    - Activation load: stream activation vectors into ping-pong bank 0.
//    - Inference: run the MAC schedule (layer, vector, neuron, input index)
//      and stream the final-layer activations out.
// Ports:
//    clk_i, rst_i              : clock and synchronous active-high reset
//    bus (mlp_seq_if.slave)    : cmd / in / out handshakes
//    abort_i                   : abandon the current operation
//    done_o                    : one-cycle completion pulse
//    w_wen_o, w_ren_o,
//    w_addr_o                  : weight memory control, address {l, j, k}
//    x_wen_o, x_ren_o,
//    x_wr_addr_o, x_rd_addr_o,
//    x_wr_bank_o, x_rd_bank_o  : ping-pong activation memory control
//    acc_clr_o, acc_en_o,
//    act_en_o                  : datapath accumulator and activation control
module mlp_seq #(
   parameter int N   = 16,
   parameter int L   = 8,
   parameter int B   = 4,
   parameter int WAW = $clog2(L) + 2 * $clog2(N),
   parameter int XAW = $clog2(B) + $clog2(N)
) (
   input  logic           clk_i,
   input  logic           rst_i,
   mlp_seq_if.slave       bus,
   input  logic           abort_i,
   output logic           done_o,
   output logic           w_wen_o,
   output logic           w_ren_o,
   output logic [WAW-1:0] w_addr_o,
   output logic           x_wen_o,
   output logic           x_ren_o,
   output logic [XAW-1:0] x_wr_addr_o,
   output logic [XAW-1:0] x_rd_addr_o,
   output logic           x_wr_bank_o,
   output logic           x_rd_bank_o,
   output logic           acc_clr_o,
   output logic           acc_en_o,
   output logic           act_en_o
);
   localparam int KW = $clog2(N);
   localparam int BW = (B > 1) ? $clog2(B) : 1;
   localparam int LW = (L > 1) ? $clog2(L) : 1;
   localparam logic [KW-1:0] KMAX = KW'(N - 1);
   localparam logic [BW-1:0] BMAX = BW'(B - 1);
   localparam logic [LW-1:0] LMAX = LW'(L - 1);
   // Bank that holds the final layer's results.
   localparam logic          LPAR = 1'(L % 2);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INITW = 3'd1,
      S_LOADX = 3'd2,
      S_MAC   = 3'd3,
      S_DRAIN = 3'd4,
      S_WB    = 3'd5,
      S_STORE = 3'd6
   } state_t;

   state_t          state_r, state_case_s, state_nx_s;
   logic [LW-1:0]   l_r;
   logic [BW-1:0]   b_r;
   logic [KW-1:0]   j_r, k_r;
   logic            rd_done_r, out_valid_r, acc_en_r;
   logic            k_last_s, j_last_s, b_last_s, l_last_s, abort_act_s;
   logic            cmd_ready_s, in_ready_s, done_s, w_wen_s, w_ren_s, x_wen_s, x_ren_s;
   logic            x_wr_bank_s, x_rd_bank_s, acc_clr_s, act_en_s;
   logic [WAW-1:0]  w_addr_s;
   logic [XAW-1:0]  x_wr_addr_s, x_rd_addr_s;

   assign k_last_s    = (k_r == KMAX);
   assign j_last_s    = (j_r == KMAX);
   assign b_last_s    = (b_r == BMAX);
   assign l_last_s    = (l_r == LMAX);
   assign abort_act_s = abort_i && (state_r != S_IDLE);

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state and per-state memory/datapath control.
   always_comb begin
      state_case_s = state_r;
      cmd_ready_s  = 1'b0;
      in_ready_s   = 1'b0;
      done_s       = 1'b0;
      w_wen_s      = 1'b0;
      w_ren_s      = 1'b0;
      x_wen_s      = 1'b0;
      x_ren_s      = 1'b0;
      x_wr_bank_s  = 1'b0;
      x_rd_bank_s  = 1'b0;
      acc_clr_s    = 1'b0;
      act_en_s     = 1'b0;
      w_addr_s     = {WAW{1'b0}};
      x_wr_addr_s  = {XAW{1'b0}};
      x_rd_addr_s  = {XAW{1'b0}};
      case (state_r)
         S_IDLE: begin
            cmd_ready_s = 1'b1;
            if (bus.cmd_valid_i) begin
               state_case_s = bus.cmd_mode_i ? S_LOADX : S_INITW;
            end else begin
               state_case_s = S_IDLE;
            end
         end
         S_INITW: begin
            in_ready_s = 1'b1;
            w_wen_s    = bus.in_valid_i;
            w_addr_s   = WAW'({l_r, j_r, k_r});
            if (bus.in_valid_i && l_last_s && j_last_s && k_last_s) begin
               done_s       = 1'b1;
               state_case_s = S_IDLE;
            end else begin
               state_case_s = S_INITW;
            end
         end
         S_LOADX: begin
            in_ready_s  = 1'b1;
            x_wen_s     = bus.in_valid_i;
            x_wr_addr_s = XAW'({b_r, k_r});
            if (bus.in_valid_i && b_last_s && k_last_s) begin
               state_case_s = S_MAC;
            end else begin
               state_case_s = S_LOADX;
            end
         end
         S_MAC: begin
            w_ren_s      = 1'b1;
            x_ren_s      = 1'b1;
            w_addr_s     = WAW'({l_r, j_r, k_r});
            x_rd_addr_s  = XAW'({b_r, k_r});
            x_rd_bank_s  = l_r[0];
            acc_clr_s    = (k_r == {KW{1'b0}});
            state_case_s = k_last_s ? S_DRAIN : S_MAC;
         end
         S_DRAIN: begin
            state_case_s = S_WB;
         end
         S_WB: begin
            x_wen_s     = 1'b1;
            x_wr_bank_s = ~l_r[0];
            x_wr_addr_s = XAW'({b_r, j_r});
            // The last layer's result is written back without activation.
            act_en_s    = ~l_last_s;
            if (l_last_s && b_last_s && j_last_s) begin
               state_case_s = S_STORE;
            end else begin
               state_case_s = S_MAC;
            end
         end
         S_STORE: begin
            x_rd_bank_s = LPAR;
            x_rd_addr_s = XAW'({b_r, k_r});
            // Only read when the output slot is free or being consumed this
            // cycle, so the memory output stays valid while stalled.
            x_ren_s     = !rd_done_r && (!out_valid_r || bus.out_ready_i);
            if (rd_done_r && out_valid_r && bus.out_ready_i) begin
               done_s       = 1'b1;
               state_case_s = S_IDLE;
            end else begin
               state_case_s = S_STORE;
            end
         end
         default: begin
            state_case_s = S_IDLE;
         end
      endcase
      state_nx_s = abort_act_s ? S_IDLE : state_case_s;
   end

   // Loop counters {l, b, j, k} and the store read-complete flag.
   always_ff @(posedge clk_i) begin
      if (rst_i || (state_nx_s == S_IDLE)) begin
         l_r       <= {LW{1'b0}};
         b_r       <= {BW{1'b0}};
         j_r       <= {KW{1'b0}};
         k_r       <= {KW{1'b0}};
         rd_done_r <= 1'b0;
      end else begin
         case (state_r)
            S_INITW: begin
               if (w_wen_s) begin
                  k_r <= k_last_s ? {KW{1'b0}} : k_r + KW'(1);
                  if (k_last_s) begin
                     j_r <= j_last_s ? {KW{1'b0}} : j_r + KW'(1);
                     if (j_last_s) begin
                        l_r <= l_last_s ? {LW{1'b0}} : l_r + LW'(1);
                     end
                  end
               end
            end
            S_LOADX, S_STORE: begin
               if (x_ren_s || (state_r == S_LOADX && x_wen_s)) begin
                  k_r <= k_last_s ? {KW{1'b0}} : k_r + KW'(1);
                  if (k_last_s) begin
                     b_r <= b_last_s ? {BW{1'b0}} : b_r + BW'(1);
                     if (b_last_s && state_r == S_STORE) begin
                        rd_done_r <= 1'b1;
                     end
                  end
               end
            end
            S_MAC: begin
               k_r <= k_last_s ? {KW{1'b0}} : k_r + KW'(1);
            end
            S_WB: begin
               j_r <= j_last_s ? {KW{1'b0}} : j_r + KW'(1);
               if (j_last_s) begin
                  b_r <= b_last_s ? {BW{1'b0}} : b_r + BW'(1);
                  if (b_last_s) begin
                     l_r <= l_last_s ? {LW{1'b0}} : l_r + LW'(1);
                  end
               end
            end
            default: begin
               k_r <= k_r;
            end
         endcase
      end
   end

   // Result-valid flag and accumulate enable (weight read delayed by the
   // one-cycle memory latency).
   always_ff @(posedge clk_i) begin
      if (rst_i || abort_act_s) begin
         out_valid_r <= 1'b0;
         acc_en_r    <= 1'b0;
      end else begin
         acc_en_r <= w_ren_s;
         if (state_r == S_STORE && x_ren_s) begin
            out_valid_r <= 1'b1;
         end else if (state_r == S_STORE && bus.out_ready_i) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign bus.cmd_ready_o = cmd_ready_s;
   assign bus.in_ready_o  = in_ready_s;
   assign bus.out_valid_o = out_valid_r;
   assign done_o          = done_s && !abort_act_s;
   assign w_wen_o         = w_wen_s;
   assign w_ren_o         = w_ren_s;
   assign w_addr_o        = w_addr_s;
   assign x_wen_o         = x_wen_s;
   assign x_ren_o         = x_ren_s;
   assign x_wr_addr_o     = x_wr_addr_s;
   assign x_rd_addr_o     = x_rd_addr_s;
   assign x_wr_bank_o     = x_wr_bank_s;
   assign x_rd_bank_o     = x_rd_bank_s;
   assign acc_clr_o       = acc_clr_s;
   assign acc_en_o        = acc_en_r;
   assign act_en_o        = act_en_s;
endmodule

// File: tb/tb_mlp_seq.sv
// tb_mlp_seq: directed self-checking bench for mlp_seq with N=4, L=2, B=2.
module tb_mlp_seq;
   localparam int N = 4, L = 2, B = 2, WAW = 5, XAW = 3;

   logic           clk_i = 1'b0;
   logic           rst_i, abort_i, done_o;
   logic           w_wen_o, w_ren_o, x_wen_o, x_ren_o, x_wr_bank_o, x_rd_bank_o;
   logic           acc_clr_o, acc_en_o, act_en_o;
   logic [WAW-1:0] w_addr_o;
   logic [XAW-1:0] x_wr_addr_o, x_rd_addr_o;
   int             tests_run = 0;
   int             tests_failed = 0;

   mlp_seq_if bus();

   mlp_seq #(.N(N), .L(L), .B(B)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .bus(bus), .abort_i(abort_i), .done_o(done_o),
      .w_wen_o(w_wen_o), .w_ren_o(w_ren_o), .w_addr_o(w_addr_o),
      .x_wen_o(x_wen_o), .x_ren_o(x_ren_o), .x_wr_addr_o(x_wr_addr_o),
      .x_rd_addr_o(x_rd_addr_o), .x_wr_bank_o(x_wr_bank_o), .x_rd_bank_o(x_rd_bank_o),
      .acc_clr_o(acc_clr_o), .acc_en_o(acc_en_o), .act_en_o(act_en_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      step();
      step();
      rst_i = 1'b0;
      #1;
      tests_run++;
      if (bus.cmd_ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready_o);
      end
      tests_run++;
      if ({bus.in_ready_o, bus.out_valid_o, done_o, w_wen_o, w_ren_o, x_wen_o, x_ren_o,
           x_wr_bank_o, x_rd_bank_o, acc_clr_o, acc_en_o, act_en_o} !== 12'h000) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b want 000000000000",
                  {bus.in_ready_o, bus.out_valid_o, done_o, w_wen_o, w_ren_o, x_wen_o, x_ren_o,
                   x_wr_bank_o, x_rd_bank_o, acc_clr_o, acc_en_o, act_en_o});
      end
      tests_run++;
      if ({w_addr_o, x_wr_addr_o, x_rd_addr_o} !== 11'h000) begin
         tests_failed++;
         $display("FAIL reset_addr: got %h want 000", {w_addr_o, x_wr_addr_o, x_rd_addr_o});
      end
      step();
   endtask

   task automatic test_stray_inputs();
      bus.in_valid_i  = 1'b1;
      bus.out_ready_i = 1'b1;
      #1;
      tests_run++;
      if ({bus.in_ready_o, w_wen_o, x_wen_o} !== 3'b000) begin
         tests_failed++;
         $display("FAIL stray_in: got %b want 000", {bus.in_ready_o, w_wen_o, x_wen_o});
      end
      step();
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b0;
      #1;
      tests_run++;
      if ({bus.cmd_ready_o, bus.out_valid_o} !== 2'b10) begin
         tests_failed++;
         $display("FAIL stray_idle: got %b want 10", {bus.cmd_ready_o, bus.out_valid_o});
      end
   endtask

   task automatic test_load_weights();
      bus.cmd_valid_i = 1'b1;
      bus.cmd_mode_i  = 1'b0;
      step();
      bus.cmd_valid_i = 1'b0;
      for (int i = 0; i < 32; i++) begin
         bus.in_valid_i = 1'b1;
         #1;
         tests_run++;
         if ({bus.in_ready_o, w_wen_o, w_addr_o} !== {2'b11, 5'(i)}) begin
            tests_failed++;
            $display("FAIL wload_beat%0d: got %h want %h", i, {bus.in_ready_o, w_wen_o, w_addr_o}, {2'b11, 5'(i)});
         end
         tests_run++;
         if (done_o !== 1'(i == 31)) begin
            tests_failed++;
            $display("FAIL wload_done%0d: got %b want %b", i, done_o, 1'(i == 31));
         end
         step();
      end
      bus.in_valid_i = 1'b0;
      #1;
      tests_run++;
      if ({bus.cmd_ready_o, done_o, bus.in_ready_o} !== 3'b100) begin
         tests_failed++;
         $display("FAIL wload_after: got %b want 100", {bus.cmd_ready_o, done_o, bus.in_ready_o});
      end
   endtask

   task automatic test_inference();
      int   cnt, reads, hcount;
      logic exp_ov, exp_xren, hs, fin;
      bus.cmd_valid_i = 1'b1;
      bus.cmd_mode_i  = 1'b1;
      step();
      bus.cmd_valid_i = 1'b0;
      cnt = 0;
      for (int cyc = 0; cyc < 32 && cnt < 8; cyc++) begin
         bus.in_valid_i = 1'((cyc % 3) != 1);
         #1;
         tests_run++;
         if ({bus.in_ready_o, x_wen_o} !== {1'b1, bus.in_valid_i}) begin
            tests_failed++;
            $display("FAIL xload_wen%0d: got %b want %b", cyc, {bus.in_ready_o, x_wen_o}, {1'b1, bus.in_valid_i});
         end
         if (bus.in_valid_i) begin
            tests_run++;
            if ({x_wr_bank_o, x_wr_addr_o} !== {1'b0, 3'(cnt)}) begin
               tests_failed++;
               $display("FAIL xload_addr%0d: got %h want %h", cnt, {x_wr_bank_o, x_wr_addr_o}, {1'b0, 3'(cnt)});
            end
            cnt++;
         end
         step();
      end
      bus.in_valid_i = 1'b0;
      for (int c = 0; c < 96; c++) begin
         int n, p, l, b, j;
         logic [15:0] got, exp;
         n = c / 6; p = c % 6; l = n / 8; b = (n / 4) % 2; j = n % 4;
         #1;
         if (p < 4) begin
            got = {2'b00, w_ren_o, x_ren_o, x_wen_o, acc_clr_o, acc_en_o, x_rd_bank_o, w_addr_o, x_rd_addr_o};
            exp = {2'b00, 3'b110, 1'(p == 0), 1'(p != 0), 1'(l % 2), 5'(l * 16 + j * 4 + p), 3'(b * 4 + p)};
         end else if (p == 4) begin
            got = {12'h000, w_ren_o, x_ren_o, x_wen_o, acc_en_o};
            exp = {12'h000, 4'b0001};
         end else begin
            got = {7'h00, w_ren_o, x_ren_o, x_wen_o, acc_en_o, x_wr_bank_o, act_en_o, x_wr_addr_o};
            exp = {7'h00, 4'b0010, 1'(l == 0), 1'(l == 0), 3'(b * 4 + j)};
         end
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL compute_c%0d: got %h want %h", c, got, exp);
         end
         step();
      end
      #1;
      tests_run++;
      if ({w_ren_o, x_ren_o, x_rd_bank_o, x_rd_addr_o} !== 6'b010000) begin
         tests_failed++;
         $display("FAIL store_entry: got %b want 010000", {w_ren_o, x_ren_o, x_rd_bank_o, x_rd_addr_o});
      end
      reads = 0; hcount = 0; exp_ov = 1'b0; fin = 1'b0;
      for (int s = 0; s < 40 && !fin; s++) begin
         bus.out_ready_i = 1'(s % 2);
         #1;
         exp_xren = 1'(reads < 8) && (!exp_ov || bus.out_ready_i);
         hs       = exp_ov && bus.out_ready_i;
         if (hs) hcount++;
         tests_run++;
         if ({x_ren_o, bus.out_valid_o, done_o} !== {exp_xren, exp_ov, 1'(hs && hcount == 8)}) begin
            tests_failed++;
            $display("FAIL store_s%0d: got %b want %b", s, {x_ren_o, bus.out_valid_o, done_o},
                     {exp_xren, exp_ov, 1'(hs && hcount == 8)});
         end
         if (exp_xren) begin
            tests_run++;
            if ({x_rd_bank_o, x_rd_addr_o} !== {1'b0, 3'(reads)}) begin
               tests_failed++;
               $display("FAIL store_addr%0d: got %h want %h", reads, {x_rd_bank_o, x_rd_addr_o}, {1'b0, 3'(reads)});
            end
            reads++;
         end
         exp_ov = exp_xren ? 1'b1 : (bus.out_ready_i ? 1'b0 : exp_ov);
         if (hs && hcount == 8) fin = 1'b1;
         step();
      end
      bus.out_ready_i = 1'b0;
      #1;
      tests_run++;
      if ({bus.cmd_ready_o, bus.out_valid_o} !== 2'b10) begin
         tests_failed++;
         $display("FAIL store_idle: got %b want 10", {bus.cmd_ready_o, bus.out_valid_o});
      end
   endtask

   task automatic test_abort();
      int  cyc, hs;
      logic seen_done;
      abort_i = 1'b1;
      bus.cmd_valid_i = 1'b1;
      bus.cmd_mode_i  = 1'b0;
      step();
      abort_i = 1'b0;
      bus.cmd_valid_i = 1'b0;
      #1;
      tests_run++;
      if ({bus.cmd_ready_o, bus.in_ready_o} !== 2'b01) begin
         tests_failed++;
         $display("FAIL abort_idle_ignored: got %b want 01", {bus.cmd_ready_o, bus.in_ready_o});
      end
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      #1;
      tests_run++;
      if ({bus.cmd_ready_o, bus.in_ready_o} !== 2'b10) begin
         tests_failed++;
         $display("FAIL abort_initw: got %b want 10", {bus.cmd_ready_o, bus.in_ready_o});
      end
      bus.cmd_valid_i = 1'b1;
      bus.cmd_mode_i  = 1'b1;
      step();
      bus.cmd_valid_i = 1'b0;
      bus.in_valid_i  = 1'b1;
      for (int i = 0; i < 8; i++) step();
      bus.in_valid_i = 1'b0;
      for (int c = 0; c < 39; c++) step();
      abort_i = 1'b1;
      #1;
      tests_run++;
      if ({w_ren_o, acc_en_o} !== 2'b11) begin
         tests_failed++;
         $display("FAIL abort_mac40: got %b want 11", {w_ren_o, acc_en_o});
      end
      step();
      abort_i = 1'b0;
      #1;
      tests_run++;
      if ({bus.cmd_ready_o, w_ren_o, x_ren_o, w_wen_o, x_wen_o, acc_clr_o, acc_en_o, act_en_o,
           bus.out_valid_o, done_o} !== 10'b10_0000_0000) begin
         tests_failed++;
         $display("FAIL abort_outputs: got %b want 1000000000",
                  {bus.cmd_ready_o, w_ren_o, x_ren_o, w_wen_o, x_wen_o, acc_clr_o, acc_en_o, act_en_o,
                   bus.out_valid_o, done_o});
      end
      bus.cmd_valid_i = 1'b1;
      step();
      bus.cmd_valid_i = 1'b0;
      bus.in_valid_i  = 1'b1;
      for (int i = 0; i < 8; i++) step();
      bus.in_valid_i = 1'b0;
      cyc = 0;
      while (cyc < 200 && !(x_ren_o && !w_ren_o)) begin
         step();
         cyc++;
      end
      tests_run++;
      if (cyc != 96) begin
         tests_failed++;
         $display("FAIL rerun_latency: got %0d want 96", cyc);
      end
      bus.out_ready_i = 1'b1;
      hs = 0;
      seen_done = 1'b0;
      for (int s = 0; s < 30 && !seen_done; s++) begin
         #1;
         if (bus.out_valid_o) hs++;
         if (done_o) seen_done = 1'b1;
         step();
      end
      bus.out_ready_i = 1'b0;
      tests_run++;
      if ({seen_done, 8'(hs)} !== {1'b1, 8'd8}) begin
         tests_failed++;
         $display("FAIL rerun_store: got done=%b beats=%0d want done=1 beats=8", seen_done, hs);
      end
   endtask

   task automatic test_reset_in_store();
      int cyc;
      bus.cmd_valid_i = 1'b1;
      bus.cmd_mode_i  = 1'b1;
      step();
      bus.cmd_valid_i = 1'b0;
      bus.in_valid_i  = 1'b1;
      for (int i = 0; i < 8; i++) step();
      bus.in_valid_i = 1'b0;
      cyc = 0;
      while (cyc < 200 && !(x_ren_o && !w_ren_o)) begin
         step();
         cyc++;
      end
      step();
      #1;
      tests_run++;
      if (bus.out_valid_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_store_pre: got %b want 1", bus.out_valid_o);
      end
      rst_i = 1'b1;
      abort_i = 1'b1;
      bus.cmd_valid_i = 1'b1;
      bus.cmd_mode_i  = 1'b0;
      step();
      rst_i = 1'b0;
      abort_i = 1'b0;
      bus.cmd_valid_i = 1'b0;
      #1;
      tests_run++;
      if ({bus.out_valid_o, bus.cmd_ready_o, bus.in_ready_o, x_ren_o} !== 4'b0100) begin
         tests_failed++;
         $display("FAIL rst_store_post: got %b want 0100",
                  {bus.out_valid_o, bus.cmd_ready_o, bus.in_ready_o, x_ren_o});
      end
   endtask

   initial begin
      rst_i           = 1'b1;
      abort_i         = 1'b0;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_mode_i  = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b0;
      test_reset();
      test_stray_inputs();
      test_load_weights();
      test_inference();
      test_abort();
      test_reset_in_store();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/mlp_seq.md
MLP_SEQ -- requirements
Module: mlp_seq

Interface
REQ-001 Parameters SHALL be: N, 16, neurons per layer (power of two, >=2); L, 8, layers (>=1); B, 4, vectors per batch (power of two, >=1); WAW = clog2(L)+2*clog2(N), weight address width (derived); XAW = clog2(B)+clog2(N), activation address width (derived).
REQ-002 clk_i  in  1  sole clock; every register updates on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 cmd_valid_i / cmd_ready_o / cmd_mode_i  in/out/in  1/1/1  command handshake; mode 0 = load weights, 1 = run inference.
REQ-005 abort_i  in  1  abandon the current operation.
REQ-006 in_valid_i / in_ready_o  in/out  1/1  input data beat handshake (weights or activations).
REQ-007 out_valid_o / out_ready_i  out/in  1/1  result beat handshake.
REQ-008 done_o  out  1  one-cycle pulse when an operation completes.
REQ-009 w_wen_o, w_ren_o  out  1 each; w_addr_o  out  WAW  weight memory control.
REQ-010 x_wen_o, x_ren_o  out  1 each; x_wr_addr_o, x_rd_addr_o  out  XAW; x_wr_bank_o, x_rd_bank_o  out  1  ping-pong activation memory control.
REQ-011 acc_clr_o, acc_en_o, act_en_o  out  1 each  accumulator clear, accumulate, apply-activation-on-writeback.

Function
REQ-012 States SHALL be IDLE, INITW, LOADX, MAC, DRAIN, WB, STORE; cmd_ready_o = 1 only in IDLE.
REQ-013 IDLE: cmd handshake with mode 0 -> INITW, mode 1 -> LOADX; all counters cleared on entry to IDLE.
REQ-014 INITW: in_ready_o = 1; each in handshake asserts w_wen_o with w_addr_o = {l, j, k} counting linearly 0..L*N*N-1; after the final beat -> IDLE with done_o pulse.
REQ-015 LOADX: in_ready_o = 1; each handshake asserts x_wen_o, x_wr_bank_o = 0, x_wr_addr_o = {b, k} linear 0..B*N-1; after the final beat -> MAC.
REQ-016 Loop order in MAC SHALL be layer l (outer), vector b, output neuron j, input index k (inner).
REQ-017 MAC: one read per cycle, w_ren_o = x_ren_o = 1, w_addr_o = {l, j, k}, x_rd_addr_o = {b, k}, x_rd_bank_o = l[0]; acc_clr_o = 1 on the k = 0 cycle; after k = N-1 -> DRAIN.
REQ-018 Memories have 1-cycle read latency; acc_en_o SHALL equal w_ren_o delayed one cycle (high in MAC cycles 2..N and in DRAIN).
REQ-019 WB: one cycle, x_wen_o = 1, x_wr_bank_o = ~l[0], x_wr_addr_o = {b, j}; act_en_o = 1 except when l = L-1; then next neuron/vector/layer -> MAC, or -> STORE after the last (l, b, j).
REQ-020 Compute latency SHALL be exactly L*B*N*(N+2) cycles from LOADX exit to STORE entry.
REQ-021 STORE: x_rd_bank_o = L[0] (parity of L); x_ren_o = 1 when beats remain and (!out_valid_o || out_ready_i); x_rd_addr_o linear 0..B*N-1; out_valid_o set the cycle after a read, held until out_ready_i; memory output is held while x_ren_o = 0.
REQ-022 The last out handshake SHALL return to IDLE with done_o pulsed in that same cycle; out_ready_i low indefinitely SHALL stall without loss or duplication.
REQ-023 abort_i in any non-IDLE state -> IDLE next cycle; all enables, out_valid_o and done_o low from that cycle; abort_i in IDLE is ignored, and a command accepted in that cycle proceeds.
REQ-024 in_valid_i outside INITW/LOADX and out_ready_i outside STORE SHALL have no effect.

Reset
REQ-025 rst_i high at a clock edge -> IDLE, all counters 0; cmd_ready_o = 1, all other outputs 0 from the next cycle, including mid-operation; rst_i overrides abort_i and cmd_valid_i.

Verification (N=4, L=2, B=2)
REQ-026 cmd mode 0, 32 in beats -> w_wen_o addresses 0..31 in order; done_o pulses on beat 32; cmd_ready_o = 1 next cycle.
REQ-027 cmd mode 1, 8 in beats with in_valid_i toggling -> x_wen_o only on handshakes, bank 0, addresses 0..7; MAC entered after beat 8; STORE entered exactly 96 cycles later.
REQ-028 During compute -> layer 0 reads bank 0 / writes bank 1 with act_en_o = 1; layer 1 reads bank 1 / writes bank 0 with act_en_o = 0; acc_en_o high for 4 cycles per neuron.
REQ-029 STORE with out_ready_i = 1 on alternate cycles -> 8 beats, read addresses 0..7 from bank 0, no duplicate or dropped beat; done_o on the 8th handshake.
REQ-030 abort_i in MAC cycle 40 -> IDLE next cycle, all enables 0; new mode 1 command runs to completion normally.
REQ-031 rst_i asserted during STORE with out_valid_o = 1 -> out_valid_o = 0 and cmd_ready_o = 1 the following cycle.
